// File: rtl/window_gen.sv
// window_gen: raster-stream sliding-window extractor.
//   Buffers WIN_ROWS-1 full image lines and, on every qualifying accepted beat,
//   registers a flattened WIN_ROWS x WIN_BEATS window with its position.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_data      pixel beat (leftmost pixel in MS bits)
//   in_valid     beat qualifier (no backpressure)
//   in_sof       start of frame, sampled with in_valid
//   win_data     window; [((k*WIN_BEATS)+c)*BW +: BW] = row k (0 = top), column c (0 = left)
//   win_valid    one-cycle strobe per window
//   win_col      beat index of the window's left column
//   win_row      line index of the window's top row
//   frame_done   one-cycle pulse after the last beat of a frame
module window_gen #(
  parameter int unsigned PIX_W      = 3,
  parameter int unsigned BEAT_PIX   = 2,
  parameter int unsigned LINE_BEATS = 92,
  parameter int unsigned LINE_NUM   = 36,
  parameter int unsigned WIN_BEATS  = 12,
  parameter int unsigned WIN_ROWS   = 24,
  parameter int unsigned H_STRIDE   = 1,
  parameter int unsigned V_STRIDE   = 1
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic [PIX_W*BEAT_PIX-1:0]                       in_data,
  input  logic                                            in_valid,
  input  logic                                            in_sof,
  output logic [WIN_ROWS*WIN_BEATS*PIX_W*BEAT_PIX-1:0]    win_data,
  output logic                                            win_valid,
  output logic [$clog2(LINE_BEATS)-1:0]                   win_col,
  output logic [$clog2(LINE_NUM)-1:0]                     win_row,
  output logic                                            frame_done
);

  localparam int unsigned BW  = PIX_W * BEAT_PIX;
  localparam int unsigned DW  = WIN_ROWS * WIN_BEATS * BW;
  localparam int unsigned CW  = $clog2(LINE_BEATS);
  localparam int unsigned RW  = $clog2(LINE_NUM);
  localparam int unsigned HPW = (H_STRIDE > 1) ? $clog2(H_STRIDE) : 1;
  localparam int unsigned VPW = (V_STRIDE > 1) ? $clog2(V_STRIDE) : 1;

  localparam logic [CW-1:0]  COL_FIRST = CW'(WIN_BEATS - 1);
  localparam logic [CW-1:0]  COL_LAST  = CW'(LINE_BEATS - 1);
  localparam logic [RW-1:0]  ROW_FIRST = RW'(WIN_ROWS - 1);
  localparam logic [RW-1:0]  ROW_LAST  = RW'(LINE_NUM - 1);
  localparam logic [HPW-1:0] HPH_LAST  = HPW'(H_STRIDE - 1);
  localparam logic [VPW-1:0] VPH_LAST  = VPW'(V_STRIDE - 1);

  // Position / phase state
  logic [CW-1:0]  col_q, col_d, cur_col;
  logic [RW-1:0]  row_q, row_d, cur_row;
  logic [HPW-1:0] hph_q, hph_d, cur_hph;
  logic [VPW-1:0] vph_q, vph_d, cur_vph;
  // Line-delay pointer runs independently of col_q so that in_sof never
  // changes the delay length of the line buffers.
  logic [CW-1:0]  ptr_q, ptr_d;

  // Storage (not reset)
  logic [BW-1:0] mem_q  [WIN_ROWS-1][LINE_BEATS];
  logic [BW-1:0] winr_q [WIN_ROWS][WIN_BEATS];
  logic [BW-1:0] tap    [WIN_ROWS];
  logic [BW-1:0] win_nxt[WIN_ROWS][WIN_BEATS];
  logic [DW-1:0] win_flat;

  // Registered outputs
  logic [DW-1:0] win_data_q;
  logic          win_valid_q;
  logic [CW-1:0] win_col_q;
  logic [RW-1:0] win_row_q;
  logic          frame_done_q;

  logic qual, line_end, frame_end;

  // Position of the current beat: an sof beat is (0,0) regardless of state.
  always_comb begin
    cur_col   = in_sof ? '0 : col_q;
    cur_row   = in_sof ? '0 : row_q;
    cur_hph   = in_sof ? '0 : hph_q;
    cur_vph   = in_sof ? '0 : vph_q;
    qual      = (cur_col >= COL_FIRST) && (cur_hph == '0) &&
                (cur_row >= ROW_FIRST) && (cur_vph == '0);
    line_end  = (cur_col == COL_LAST);
    frame_end = line_end && (cur_row == ROW_LAST);

    col_d = line_end ? '0 : cur_col + 1'b1;
    hph_d = '0;
    if (!line_end && (cur_col >= COL_FIRST))
      hph_d = (cur_hph == HPH_LAST) ? '0 : cur_hph + 1'b1;

    row_d = cur_row;
    vph_d = cur_vph;
    if (line_end) begin
      row_d = frame_end ? '0 : cur_row + 1'b1;
      vph_d = '0;
      if (!frame_end && (cur_row >= ROW_FIRST))
        vph_d = (cur_vph == VPH_LAST) ? '0 : cur_vph + 1'b1;
    end

    ptr_d = (ptr_q == COL_LAST) ? '0 : ptr_q + 1'b1;
  end

  // Line taps and the window as it stands after the current beat is shifted in.
  always_comb begin
    for (int unsigned k = 0; k < WIN_ROWS - 1; k++)
      tap[k] = mem_q[k][ptr_q];
    tap[WIN_ROWS-1] = in_data;
    for (int unsigned k = 0; k < WIN_ROWS; k++) begin
      for (int unsigned c = 0; c < WIN_BEATS - 1; c++)
        win_nxt[k][c] = winr_q[k][c+1];
      win_nxt[k][WIN_BEATS-1] = tap[k];
    end
    win_flat = '0;
    for (int unsigned k = 0; k < WIN_ROWS; k++)
      for (int unsigned c = 0; c < WIN_BEATS; c++)
        win_flat[((k*WIN_BEATS)+c)*BW +: BW] = win_nxt[k][c];
  end

  // Line delays chain newest -> oldest; each stage reads before it writes.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int unsigned k = 0; k < WIN_ROWS - 1; k++)
        mem_q[k][ptr_q] <= tap[k+1];
      for (int unsigned k = 0; k < WIN_ROWS; k++)
        for (int unsigned c = 0; c < WIN_BEATS; c++)
          winr_q[k][c] <= win_nxt[k][c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      hph_q        <= '0;
      vph_q        <= '0;
      ptr_q        <= '0;
      win_data_q   <= '0;
      win_valid_q  <= 1'b0;
      win_col_q    <= '0;
      win_row_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      win_valid_q  <= in_valid && qual;
      frame_done_q <= in_valid && frame_end && !in_sof;
      if (in_valid) begin
        col_q <= col_d;
        row_q <= row_d;
        hph_q <= hph_d;
        vph_q <= vph_d;
        ptr_q <= ptr_d;
        if (qual) begin
          win_data_q <= win_flat;
          win_col_q  <= cur_col - COL_FIRST;
          win_row_q  <= cur_row - ROW_FIRST;
        end
      end
    end
  end

  assign win_data   = win_data_q;
  assign win_valid  = win_valid_q;
  assign win_col    = win_col_q;
  assign win_row    = win_row_q;
  assign frame_done = frame_done_q;

endmodule
